// File: rtl/simon_input_checker_pkg.sv
// rtl/simon_input_checker_pkg.sv - shared types and constants for the Simon input checker
package simon_input_checker_pkg;

  localparam int BTN_W = 4;
  localparam int NUM_W = 2;

  // Button-to-num encoding, also used by the LED and frequency mappers
  localparam logic [NUM_W-1:0] NUM_BTN0 = 2'd0;
  localparam logic [NUM_W-1:0] NUM_BTN1 = 2'd1;
  localparam logic [NUM_W-1:0] NUM_BTN2 = 2'd2;
  localparam logic [NUM_W-1:0] NUM_BTN3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HELD,
    ST_DONE,
    ST_FAIL
  } state_t;

endpackage

// File: rtl/simon_input_checker_if.sv
// rtl/simon_input_checker_if.sv - button/sequence/status bundle between game core and checker
interface simon_input_checker_if
  import simon_input_checker_pkg::*;
#(
  parameter int MAX_LEN = 32
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [BTN_W-1:0]  btns;
  logic              start;
  logic [5:0]        round_len;
  logic [ADDR_W-1:0] seq_addr;
  logic [NUM_W-1:0]  seq_num;
  logic [NUM_W-1:0]  num;
  logic              pressed;
  logic              busy;
  logic              round_ok;
  logic              game_over;

  // Game core side
  modport master (
    output btns, start, round_len, seq_num,
    input  seq_addr, num, pressed, busy, round_ok, game_over
  );

  // Checker side
  modport slave (
    input  btns, start, round_len, seq_num,
    output seq_addr, num, pressed, busy, round_ok, game_over
  );

endinterface

// File: rtl/simon_input_checker_btn_debouncer.sv
// rtl/simon_input_checker_btn_debouncer.sv - 2-FF synchronizer plus stability counter for one button
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic btn_o
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // Count consecutive cycles at the new level; flip once the count completes
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, counter and debounced level registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign btn_o = db_q;

endmodule

// File: rtl/simon_input_checker.sv
// rtl/simon_input_checker.sv - debounces player buttons and checks them against the stored sequence
module simon_input_checker
  import simon_input_checker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 250_000_000,
  parameter int MAX_LEN         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  simon_input_checker_if.slave bus
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W  = 6;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  logic [BTN_W-1:0]  db;
  logic [BTN_W-1:0]  db_prev_q;
  logic              onehot_d;
  logic [NUM_W-1:0]  enc_d;
  logic              press_d;
  logic              last_d;
  logic [LEN_W-1:0]  len_d;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [ADDR_W-1:0] seq_addr_q;
  logic [NUM_W-1:0]  num_q;
  logic              pressed_q;
  logic              busy_q;
  logic              round_ok_q;
  logic              game_over_q;

  for (genvar g = 0; g < BTN_W; g++) begin : g_db
    btn_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk),
      .rst_n_i(reset),
      .btn_i  (bus.btns[g]),
      .btn_o  (db[g])
    );
  end

  // One-hot detection and encoding; a press counts only when leaving 0000
  always_comb begin
    onehot_d = 1'b1;
    enc_d    = NUM_BTN0;
    case (db)
      4'b0001: enc_d = NUM_BTN0;
      4'b0010: enc_d = NUM_BTN1;
      4'b0100: enc_d = NUM_BTN2;
      4'b1000: enc_d = NUM_BTN3;
      default: onehot_d = 1'b0;
    endcase
    press_d = onehot_d && (db_prev_q == '0);
    last_d  = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    len_d   = (bus.round_len > LEN_MAX) ? LEN_MAX : bus.round_len;
  end

  // Previous debounced vector for press-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_prev_q <= '0;
    end else begin
      db_prev_q <= db;
    end
  end

  // Round-checking FSM with registered outputs; start overrides every other event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      seq_addr_q  <= '0;
      num_q       <= '0;
      pressed_q   <= 1'b0;
      busy_q      <= 1'b0;
      round_ok_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      round_ok_q <= 1'b0;
      if (bus.start) begin
        idx_q       <= '0;
        tmo_q       <= '0;
        seq_addr_q  <= '0;
        pressed_q   <= 1'b0;
        game_over_q <= 1'b0;
        len_q       <= len_d;
        if (bus.round_len != '0) begin
          state_q <= ST_WAIT;
          busy_q  <= 1'b1;
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
          end
          ST_WAIT: begin
            tmo_q <= tmo_q + TMO_W'(1);
            if (press_d) begin
              num_q     <= enc_d;
              pressed_q <= 1'b1;
              if (enc_d == bus.seq_num) begin
                state_q <= ST_HELD;
              end else begin
                state_q     <= ST_FAIL;
                game_over_q <= 1'b1;
                busy_q      <= 1'b0;
              end
            end else if (tmo_q == TMO_LAST) begin
              state_q     <= ST_FAIL;
              game_over_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
          ST_HELD: begin
            if (db == '0) begin
              pressed_q <= 1'b0;
              if (last_d) begin
                state_q    <= ST_DONE;
                round_ok_q <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                idx_q      <= idx_q + ADDR_W'(1);
                seq_addr_q <= idx_q + ADDR_W'(1);
                tmo_q      <= '0;
                state_q    <= ST_WAIT;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          ST_FAIL: begin
            if (db == '0) begin
              pressed_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.seq_addr  = seq_addr_q;
  assign bus.num       = num_q;
  assign bus.pressed   = pressed_q;
  assign bus.busy      = busy_q;
  assign bus.round_ok  = round_ok_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_simon_input_checker.sv
// tb/tb_simon_input_checker.sv - scoreboard bench for simon_input_checker
module tb_simon_input_checker;

  localparam int EV_P = 1;
  localparam int EV_R = 2;
  localparam int EV_G = 3;

  typedef struct {
    int kind;
    int num;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];
  logic [1:0] seq_mem [32];
  logic pr_prev = 1'b0;
  logic go_prev = 1'b0;

  simon_input_checker_if #(.MAX_LEN(32)) bus ();

  simon_input_checker #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (100),
    .MAX_LEN        (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.seq_num = seq_mem[bus.seq_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic consume(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", kind, 0);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", kind, e.kind);
      if (kind == EV_P) check("sb_num", val, e.num);
    end
  endtask

  // Output monitor: turns pressed/round_ok/game_over edges into scoreboard events
  always @(negedge clk) begin
    if (bus.pressed && !pr_prev) consume(EV_P, int'(bus.num));
    if (bus.round_ok) consume(EV_R, 0);
    if (bus.game_over && !go_prev) consume(EV_G, 0);
    pr_prev <= bus.pressed;
    go_prev <= bus.game_over;
  end

  task automatic start_round(input int len);
    bus.round_len = 6'(len);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    bus.btns = b;
    repeat (hold) @(negedge clk);
    bus.btns = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    bus.btns = 4'b0000;
    bus.start = 1'b0;
    bus.round_len = 6'd0;
    for (int i = 0; i < 32; i++) seq_mem[i] = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_seq_addr", int'(bus.seq_addr), 0);
    check("rst_num", int'(bus.num), 0);
    check("rst_pressed", int'(bus.pressed), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_round_ok", int'(bus.round_ok), 0);
    check("rst_game_over", int'(bus.game_over), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Correct round {2,0,3}
    seq_mem[0] = 2'd2; seq_mem[1] = 2'd0; seq_mem[2] = 2'd3;
    start_round(3);
    check("ok_busy_after_start", int'(bus.busy), 1);
    exp_q.push_back('{EV_P, 2});
    press(4'b0100, 16);
    repeat (10) @(negedge clk);
    check("ok_addr1", int'(bus.seq_addr), 1);
    exp_q.push_back('{EV_P, 0});
    press(4'b0001, 16);
    repeat (10) @(negedge clk);
    check("ok_addr2", int'(bus.seq_addr), 2);
    exp_q.push_back('{EV_P, 3});
    exp_q.push_back('{EV_R, 0});
    press(4'b1000, 16);
    n = 0;
    while (!bus.round_ok && n < 50) begin @(negedge clk); n++; end
    check("ok_round_ok_latency", n, 7);
    @(negedge clk);
    check("ok_round_ok_one_cycle", int'(bus.round_ok), 0);
    check("ok_busy_done", int'(bus.busy), 0);
    check("ok_game_over", int'(bus.game_over), 0);
    repeat (5) @(negedge clk);

    // Wrong button
    seq_mem[0] = 2'd1;
    start_round(2);
    exp_q.push_back('{EV_P, 0});
    exp_q.push_back('{EV_G, 0});
    bus.btns = 4'b0001;
    n = 0;
    while (!bus.game_over && n < 50) begin @(negedge clk); n++; end
    check("wrong_latency", n, 7);
    check("wrong_num", int'(bus.num), 0);
    check("wrong_busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    bus.btns = 4'b0000;
    repeat (10) @(negedge clk);
    check("wrong_sticky", int'(bus.game_over), 1);
    check("wrong_released", int'(bus.pressed), 0);

    // Bounce: one press registered, idx advances once
    seq_mem[0] = 2'd1; seq_mem[1] = 2'd2;
    start_round(2);
    exp_q.push_back('{EV_P, 1});
    for (int i = 0; i < 5; i++) begin
      bus.btns = 4'b0010;
      repeat (2) @(negedge clk);
      bus.btns = 4'b0000;
      repeat (2) @(negedge clk);
    end
    press(4'b0010, 16);
    repeat (10) @(negedge clk);
    check("bounce_addr", int'(bus.seq_addr), 1);
    check("bounce_busy", int'(bus.busy), 1);
    check("bounce_game_over", int'(bus.game_over), 0);

    // Timeout
    exp_q.push_back('{EV_G, 0});
    start_round(3);
    n = 0;
    while (!bus.game_over && n < 300) begin @(negedge clk); n++; end
    check("timeout_latency", n, 100);
    repeat (3) @(negedge clk);

    // Multi-press ignored, then restart during FAIL
    seq_mem[0] = 2'd0;
    start_round(2);
    seen = 0;
    bus.btns = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.pressed || bus.game_over) seen++;
    end
    bus.btns = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pressed || bus.game_over) seen++;
    end
    check("multi_ignored", seen, 0);
    exp_q.push_back('{EV_P, 1});
    exp_q.push_back('{EV_G, 0});
    bus.btns = 4'b0010;
    n = 0;
    while (!bus.game_over && n < 50) begin @(negedge clk); n++; end
    check("multi_fail_latency", n, 7);
    start_round(2);
    check("restart_game_over", int'(bus.game_over), 0);
    check("restart_seq_addr", int'(bus.seq_addr), 0);
    check("restart_busy", int'(bus.busy), 1);
    bus.btns = 4'b0000;
    repeat (10) @(negedge clk);

    // Async reset mid-HELD
    seq_mem[0] = 2'd2;
    start_round(2);
    exp_q.push_back('{EV_P, 2});
    bus.btns = 4'b0100;
    n = 0;
    while (!bus.pressed && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("areset_pre_pressed", int'(bus.pressed), 1);
    #2 reset = 1'b0;
    #1;
    check("areset_seq_addr", int'(bus.seq_addr), 0);
    check("areset_num", int'(bus.num), 0);
    check("areset_pressed", int'(bus.pressed), 0);
    check("areset_busy", int'(bus.busy), 0);
    check("areset_round_ok", int'(bus.round_ok), 0);
    check("areset_game_over", int'(bus.game_over), 0);
    bus.btns = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
